llc_input_sched: RTL and testbench

//  Parametrised input scheduler in front of the LLC core decode stage. Arbitrates one response

---
 rtl/llc_input_sched.sv | 164 ++++++++++++++++
 tb/tb_llc_input_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_input_sched.sv
// Input scheduler for the LLC decode stage: arbitrates response, coherence-request and DMA
// channels into one registered message slot drained through a valid/ready handshake.
module llc_input_sched #(
    parameter int unsigned NUM_REQ_CH = 2,
    parameter int unsigned ADDR_W     = 26,
    parameter int unsigned MSG_W      = 5,
    parameter int unsigned SET_BITS   = 9,
    parameter int unsigned STARVE_MAX = 15,
    parameter int unsigned RR_MODE    = 1,
    localparam int unsigned CH_W      = (NUM_REQ_CH > 1) ? $clog2(NUM_REQ_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rsp_in_valid,
    output logic                         rsp_in_ready,
    input  logic [ADDR_W-1:0]            rsp_in_addr,
    input  logic [NUM_REQ_CH-1:0]        req_in_valid,
    output logic [NUM_REQ_CH-1:0]        req_in_ready,
    input  logic [NUM_REQ_CH*ADDR_W-1:0] req_in_addr,
    input  logic [NUM_REQ_CH*MSG_W-1:0]  req_in_msg,
    input  logic                         dma_in_valid,
    output logic                         dma_in_ready,
    input  logic [ADDR_W-1:0]            dma_in_addr,
    input  logic                         set_conflict,
    input  logic [SET_BITS-1:0]          stalled_set,
    input  logic                         mshr_full,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   out_src,
    output logic [CH_W-1:0]              out_ch,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [MSG_W-1:0]             out_msg
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
    typedef enum logic [1:0] {SRC_RSP = 2'd0, SRC_REQ = 2'd1, SRC_DMA = 2'd2} src_e;

    state_e                  state;
    logic [CH_W-1:0]         rr_ptr;
    logic [7:0]              starve_cnt;

    logic                    load;
    logic                    starved;
    logic [NUM_REQ_CH-1:0]   elig;
    logic                    hi_found, lo_found, req_found;
    logic [CH_W-1:0]         hi_sel, lo_sel, req_sel;
    logic                    gnt_rsp, gnt_req, gnt_dma, gnt_any;
    logic [ADDR_W-1:0]       req_addr;
    logic [MSG_W-1:0]        req_msg;

    assign out_valid = (state == FULL);
    assign load      = !out_valid || out_ready;
    assign starved   = (starve_cnt == STARVE_LIM);

    // Channels addressing the stalled set, or any channel while MSHRs are exhausted, sit out.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NUM_REQ_CH; i++) begin
            elig[i] = req_in_valid[i] && !mshr_full &&
                      !(set_conflict && (req_in_addr[i*ADDR_W +: SET_BITS] == stalled_set));
        end
    end

    // Round-robin: lowest eligible index at or above rr_ptr, else wrap to lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int i = int'(NUM_REQ_CH) - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_found = 1'b1;
                lo_sel   = CH_W'(i);
                if (CH_W'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_sel   = CH_W'(i);
                end
            end
        end
        req_found = lo_found;
        req_sel   = lo_sel;
        if (RR_MODE != 0 && hi_found) begin
            req_sel = hi_sel;
        end
    end

    always_comb begin
        req_addr = '0;
        req_msg  = '0;
        for (int unsigned i = 0; i < NUM_REQ_CH; i++) begin
            if (CH_W'(i) == req_sel) begin
                req_addr = req_in_addr[i*ADDR_W +: ADDR_W];
                req_msg  = req_in_msg[i*MSG_W +: MSG_W];
            end
        end
    end

    // Fixed priority: rsp, starved dma, request, dma.
    always_comb begin
        gnt_rsp = 1'b0;
        gnt_req = 1'b0;
        gnt_dma = 1'b0;
        if (rst && load) begin
            if (rsp_in_valid) begin
                gnt_rsp = 1'b1;
            end else if (dma_in_valid && starved) begin
                gnt_dma = 1'b1;
            end else if (req_found) begin
                gnt_req = 1'b1;
            end else if (dma_in_valid) begin
                gnt_dma = 1'b1;
            end
        end
    end

    assign gnt_any      = gnt_rsp || gnt_req || gnt_dma;
    assign rsp_in_ready = gnt_rsp;
    assign dma_in_ready = gnt_dma;
    assign req_in_ready = gnt_req ? (NUM_REQ_CH'(1) << req_sel) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= EMPTY;
            out_src    <= '0;
            out_ch     <= '0;
            out_addr   <= '0;
            out_msg    <= '0;
            rr_ptr     <= '0;
            starve_cnt <= '0;
        end else begin
            if (load) begin
                state <= gnt_any ? FULL : EMPTY;
                if (gnt_rsp) begin
                    out_src  <= SRC_RSP;
                    out_ch   <= '0;
                    out_addr <= rsp_in_addr;
                    out_msg  <= '0;
                end else if (gnt_req) begin
                    out_src  <= SRC_REQ;
                    out_ch   <= req_sel;
                    out_addr <= req_addr;
                    out_msg  <= req_msg;
                end else if (gnt_dma) begin
                    out_src  <= SRC_DMA;
                    out_ch   <= '0;
                    out_addr <= dma_in_addr;
                    out_msg  <= '0;
                end
            end
            if (gnt_req) begin
                rr_ptr <= (req_sel == CH_W'(NUM_REQ_CH - 1)) ? '0 : req_sel + CH_W'(1);
            end
            // DMA waits are only counted when something else took the slot.
            if (gnt_dma) begin
                starve_cnt <= '0;
            end else if (dma_in_valid && (gnt_rsp || gnt_req) && starve_cnt < STARVE_LIM) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_llc_input_sched.sv
// Bench for llc_input_sched: directed vector table, hand sequences for stall and reset,
// then randomized traffic against a behavioural reference model.
module tb_llc_input_sched;

    localparam int NCH  = 2;
    localparam int AW   = 26;
    localparam int MW   = 5;
    localparam int SB   = 9;
    localparam int SMAX = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              rsp_in_valid, rsp_in_ready;
    logic [AW-1:0]     rsp_in_addr;
    logic [NCH-1:0]    req_in_valid, req_in_ready;
    logic [NCH*AW-1:0] req_in_addr;
    logic [NCH*MW-1:0] req_in_msg;
    logic              dma_in_valid, dma_in_ready;
    logic [AW-1:0]     dma_in_addr;
    logic              set_conflict;
    logic [SB-1:0]     stalled_set;
    logic              mshr_full;
    logic              out_valid, out_ready;
    logic [1:0]        out_src;
    logic [0:0]        out_ch;
    logic [AW-1:0]     out_addr;
    logic [MW-1:0]     out_msg;

    logic [AW-1:0] ch_addr [NCH];
    logic [MW-1:0] ch_msg  [NCH];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            req_in_addr[i*AW +: AW] = ch_addr[i];
            req_in_msg[i*MW +: MW]  = ch_msg[i];
        end
    end

    llc_input_sched #(
        .NUM_REQ_CH(NCH), .ADDR_W(AW), .MSG_W(MW), .SET_BITS(SB),
        .STARVE_MAX(SMAX), .RR_MODE(1)
    ) dut (
        .clk(clk), .rst(rst),
        .rsp_in_valid(rsp_in_valid), .rsp_in_ready(rsp_in_ready), .rsp_in_addr(rsp_in_addr),
        .req_in_valid(req_in_valid), .req_in_ready(req_in_ready),
        .req_in_addr(req_in_addr), .req_in_msg(req_in_msg),
        .dma_in_valid(dma_in_valid), .dma_in_ready(dma_in_ready), .dma_in_addr(dma_in_addr),
        .set_conflict(set_conflict), .stalled_set(stalled_set), .mshr_full(mshr_full),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_ch(out_ch),
        .out_addr(out_addr), .out_msg(out_msg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state and next-state
    bit            m_valid, n_valid;
    int            m_src, n_src, m_ch, n_ch, m_rr, n_rr, m_starve, n_starve;
    logic [AW-1:0] m_addr, n_addr;
    logic [MW-1:0] m_msg, n_msg;
    bit            e_rsp, e_dma;
    logic [NCH-1:0] e_req;

    function automatic bit m_elig(int ch);
        return req_in_valid[ch] && !mshr_full &&
               !(set_conflict && (ch_addr[ch][SB-1:0] == stalled_set));
    endfunction

    // Grant decision from the priority rules; request pick = eligible channel nearest to rr
    task automatic model_eval();
        int best, bestd, d;
        e_rsp = 0; e_dma = 0; e_req = '0;
        n_valid = m_valid; n_src = m_src; n_ch = m_ch; n_addr = m_addr; n_msg = m_msg;
        n_rr = m_rr; n_starve = m_starve;
        if (!rst) begin
            n_valid = 0; n_src = 0; n_ch = 0; n_addr = '0; n_msg = '0; n_rr = 0; n_starve = 0;
            return;
        end
        if (m_valid && !out_ready) return;
        best = -1; bestd = NCH;
        for (int c = 0; c < NCH; c++) begin
            d = (c - m_rr + NCH) % NCH;
            if (m_elig(c) && d < bestd) begin best = c; bestd = d; end
        end
        if (rsp_in_valid) begin
            e_rsp = 1; n_valid = 1; n_src = 0; n_ch = 0; n_addr = rsp_in_addr; n_msg = '0;
        end else if (dma_in_valid && m_starve == SMAX) begin
            e_dma = 1;
        end else if (best >= 0) begin
            e_req[best] = 1'b1; n_valid = 1; n_src = 1; n_ch = best;
            n_addr = ch_addr[best]; n_msg = ch_msg[best]; n_rr = (best + 1) % NCH;
        end else if (dma_in_valid) begin
            e_dma = 1;
        end else begin
            n_valid = 0;
        end
        if (e_dma) begin
            n_valid = 1; n_src = 2; n_ch = 0; n_addr = dma_in_addr; n_msg = '0; n_starve = 0;
        end else if (dma_in_valid && (e_rsp || e_req != '0) && m_starve < SMAX) begin
            n_starve = m_starve + 1;
        end
    endtask

    task automatic pre_edge();
        #2;
        model_eval();
        chk("m_rsp_ready", 64'(rsp_in_ready), 64'(e_rsp));
        chk("m_req_ready", 64'(req_in_ready), 64'(e_req));
        chk("m_dma_ready", 64'(dma_in_ready), 64'(e_dma));
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
        m_valid = n_valid; m_src = n_src; m_ch = n_ch; m_addr = n_addr; m_msg = n_msg;
        m_rr = n_rr; m_starve = n_starve;
        chk("m_out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            chk("m_out_src",  64'(out_src),  64'(m_src));
            chk("m_out_ch",   64'(out_ch),   64'(m_ch));
            chk("m_out_addr", 64'(out_addr), 64'(m_addr));
            chk("m_out_msg",  64'(out_msg),  64'(m_msg));
        end
        chk("m_rr_ptr",     64'(dut.rr_ptr),     64'(m_rr));
        chk("m_starve_cnt", 64'(dut.starve_cnt), 64'(m_starve));
    endtask

    typedef struct {
        logic       rsp;
        logic [1:0] req;
        logic       dma, sc, mshr;
        logic       e_rsp;
        logic [1:0] e_req;
        logic       e_dma, e_ov;
        logic [1:0] e_src;
        logic       e_ch;
        int         e_rr, e_st;
    } vec_t;

    function automatic vec_t mk(logic rsp, logic [1:0] req, logic dma, logic sc, logic mshr,
                                logic er, logic [1:0] eq, logic ed, logic ov, logic [1:0] src,
                                logic ch, int rr, int st);
        vec_t v;
        v.rsp = rsp; v.req = req; v.dma = dma; v.sc = sc; v.mshr = mshr;
        v.e_rsp = er; v.e_req = eq; v.e_dma = ed; v.e_ov = ov; v.e_src = src; v.e_ch = ch;
        v.e_rr = rr; v.e_st = st;
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = AW'($urandom);
        case ($urandom_range(0, 2))
            0: a[SB-1:0] = 9'h012;
            1: a[SB-1:0] = 9'h013;
            default: ;
        endcase
        return a;
    endfunction

    localparam logic [AW-1:0] RSP_ADDR = 26'h2AB_C001;
    localparam logic [AW-1:0] DMA_ADDR = 26'h155_4321;

    vec_t tbl [15];

    initial begin
        // rsp, req, dma, sc, mshr | rsp_rdy, req_rdy, dma_rdy | ov, src, ch | rr, starve
        tbl[0]  = mk(0, 2'b11, 0, 0, 0, 0, 2'b01, 0, 1, 2'd1, 0, 1, 0);
        tbl[1]  = mk(0, 2'b11, 0, 0, 0, 0, 2'b10, 0, 1, 2'd1, 1, 0, 0);
        tbl[2]  = mk(0, 2'b11, 0, 0, 0, 0, 2'b01, 0, 1, 2'd1, 0, 1, 0);
        tbl[3]  = mk(0, 2'b11, 0, 0, 0, 0, 2'b10, 0, 1, 2'd1, 1, 0, 0);
        tbl[4]  = mk(1, 2'b01, 1, 0, 0, 1, 2'b00, 0, 1, 2'd0, 0, 0, 1);
        tbl[5]  = mk(0, 2'b01, 1, 0, 0, 0, 2'b01, 0, 1, 2'd1, 0, 1, 2);
        tbl[6]  = mk(0, 2'b11, 0, 1, 0, 0, 2'b10, 0, 1, 2'd1, 1, 0, 2);
        tbl[7]  = mk(0, 2'b11, 0, 1, 0, 0, 2'b10, 0, 1, 2'd1, 1, 0, 2);
        tbl[8]  = mk(0, 2'b11, 1, 0, 1, 0, 2'b00, 1, 1, 2'd2, 0, 0, 0);
        tbl[9]  = mk(0, 2'b11, 1, 0, 0, 0, 2'b01, 0, 1, 2'd1, 0, 1, 1);
        tbl[10] = mk(0, 2'b11, 1, 0, 0, 0, 2'b10, 0, 1, 2'd1, 1, 0, 2);
        tbl[11] = mk(0, 2'b11, 1, 0, 0, 0, 2'b01, 0, 1, 2'd1, 0, 1, 3);
        tbl[12] = mk(0, 2'b11, 1, 0, 0, 0, 2'b00, 1, 1, 2'd2, 0, 1, 0);
        tbl[13] = mk(0, 2'b11, 0, 0, 0, 0, 2'b10, 0, 1, 2'd1, 1, 0, 0);
        tbl[14] = mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'd0, 0, 0, 0);

        rst = 1'b0;
        rsp_in_valid = 0; req_in_valid = '0; dma_in_valid = 0;
        rsp_in_addr = RSP_ADDR; dma_in_addr = DMA_ADDR;
        ch_addr[0] = 26'h000_0012; ch_addr[1] = 26'h000_0213;
        ch_msg[0] = 5'd3; ch_msg[1] = 5'd7;
        set_conflict = 0; stalled_set = 9'h012; mshr_full = 0; out_ready = 1;

        repeat (2) @(posedge clk);
        #1;
        m_valid = 0; m_src = 0; m_ch = 0; m_addr = '0; m_msg = '0; m_rr = 0; m_starve = 0;
        rsp_in_valid = 1; req_in_valid = 2'b11; dma_in_valid = 1;
        #1;
        chk("rst_ready", 64'({rsp_in_ready, req_in_ready, dma_in_ready}), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_fields", 64'({out_src, out_ch, out_addr, out_msg}), 64'(0));
        chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'(0));
        chk("rst_starve", 64'(dut.starve_cnt), 64'(0));
        rsp_in_valid = 0; req_in_valid = '0; dma_in_valid = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed vector table
        for (int r = 0; r < 15; r++) begin
            rsp_in_valid = tbl[r].rsp; req_in_valid = tbl[r].req; dma_in_valid = tbl[r].dma;
            set_conflict = tbl[r].sc; mshr_full = tbl[r].mshr; out_ready = 1;
            pre_edge();
            chk($sformatf("t%0d_rsp_ready", r), 64'(rsp_in_ready), 64'(tbl[r].e_rsp));
            chk($sformatf("t%0d_req_ready", r), 64'(req_in_ready), 64'(tbl[r].e_req));
            chk($sformatf("t%0d_dma_ready", r), 64'(dma_in_ready), 64'(tbl[r].e_dma));
            post_edge();
            chk($sformatf("t%0d_out_valid", r), 64'(out_valid), 64'(tbl[r].e_ov));
            if (tbl[r].e_ov) begin
                chk($sformatf("t%0d_out_src", r), 64'(out_src), 64'(tbl[r].e_src));
                chk($sformatf("t%0d_out_ch", r), 64'(out_ch), 64'(tbl[r].e_ch));
            end
            chk($sformatf("t%0d_rr_ptr", r), 64'(dut.rr_ptr), 64'(tbl[r].e_rr));
            chk($sformatf("t%0d_starve", r), 64'(dut.starve_cnt), 64'(tbl[r].e_st));
        end

        // Backpressure: fill, hold 5 cycles, then consume and refill together
        rsp_in_valid = 1; req_in_valid = 2'b11; dma_in_valid = 1; out_ready = 0;
        pre_edge();
        chk("bp_fill_rsp_ready", 64'(rsp_in_ready), 64'(1));
        post_edge();
        chk("bp_fill_src", 64'({out_valid, out_src}), 64'(3'b100));
        for (int k = 0; k < 5; k++) begin
            pre_edge();
            chk("bp_stall_ready", 64'({rsp_in_ready, req_in_ready, dma_in_ready}), 64'(0));
            post_edge();
            chk("bp_stall_hold", 64'({out_valid, out_src, out_addr}), 64'({1'b1, 2'd0, RSP_ADDR}));
        end
        rsp_in_valid = 0; out_ready = 1;
        pre_edge();
        chk("bp_refill_req_ready", 64'(req_in_ready), 64'(2'b01));
        post_edge();
        chk("bp_refill_out", 64'({out_valid, out_src, out_ch, out_addr, out_msg}),
            64'({1'b1, 2'd1, 1'b0, ch_addr[0], ch_msg[0]}));
        chk("bp_refill_starve", 64'(dut.starve_cnt), 64'(2));

        // Reset while the slot is full
        rst = 0; rsp_in_valid = 1; req_in_valid = 2'b11; dma_in_valid = 1;
        pre_edge();
        chk("rst_full_ready", 64'({rsp_in_ready, req_in_ready, dma_in_ready}), 64'(0));
        post_edge();
        chk("rst_full_state", 64'({out_valid, dut.rr_ptr, dut.starve_cnt}), 64'(0));
        rst = 1;

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 99) >= 2);
            rsp_in_valid = ($urandom_range(0, 99) < 25);
            req_in_valid = NCH'($urandom);
            dma_in_valid = ($urandom_range(0, 99) < 50);
            set_conflict = ($urandom_range(0, 99) < 30);
            stalled_set  = $urandom_range(0, 1) ? 9'h012 : 9'h013;
            mshr_full    = ($urandom_range(0, 99) < 15);
            out_ready    = ($urandom_range(0, 99) < 70);
            rsp_in_addr  = rand_addr();
            dma_in_addr  = rand_addr();
            for (int i = 0; i < NCH; i++) begin
                ch_addr[i] = rand_addr();
                ch_msg[i]  = MW'($urandom);
            end
            pre_edge();
            post_edge();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
